// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with CDB capture, in-order commit and mispredict flush.
// Define ROB_BYPASS_EN to let operand lookups see a same-cycle CDB hit.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             de_in_en,
  input  logic [4:0]       de_dest_in,
  input  logic             de_is_br_in,
  input  logic             de_pred_in,
  input  logic [31:0]      de_alt_pc_in,
  output logic             full,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             cdb_en,
  input  logic [IDX_W-1:0] cdb_idx,
  input  logic [31:0]      cdb_val,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_rdy,
  output logic             q2_rdy,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             rob_in_en,
  output logic [IDX_W-1:0] rob_idx_out,
  output logic [4:0]       rob_dest_out,
  output logic [31:0]      rob_val_out,
  output logic             roll_back,
  output logic [31:0]      redirect_pc
);
  logic [ROB_SIZE-1:0] busy, ready, is_br, pred;
  logic [4:0]          dest   [ROB_SIZE];
  logic [31:0]         value  [ROB_SIZE];
  logic [31:0]         alt_pc [ROB_SIZE];
  logic [IDX_W-1:0]    head, tail;
  logic [IDX_W:0]      count, count_nxt;
  logic                do_alloc, do_wb, do_ret, mispred;
  assign alloc_idx = tail;
  always_comb begin
    do_alloc  = rdy_in && !roll_back && de_in_en && !full;
    do_wb     = rdy_in && !roll_back && cdb_en && busy[cdb_idx];
    do_ret    = rdy_in && !roll_back && busy[head] && ready[head];
    mispred   = is_br[head] && (value[head][0] != pred[head]);
    count_nxt = count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_ret);
  end
`ifdef ROB_BYPASS_EN
  logic q1_hit, q2_hit;
  assign q1_hit = cdb_en && cdb_idx == q1_idx;
  assign q2_hit = cdb_en && cdb_idx == q2_idx;
  assign q1_rdy = q1_hit || ready[q1_idx];
  assign q2_rdy = q2_hit || ready[q2_idx];
  assign q1_val = q1_hit ? cdb_val : value[q1_idx];
  assign q2_val = q2_hit ? cdb_val : value[q2_idx];
`else
  assign q1_rdy = ready[q1_idx];
  assign q2_rdy = ready[q2_idx];
  assign q1_val = value[q1_idx];
  assign q2_val = value[q2_idx];
`endif
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      busy         <= '0;
      ready        <= '0;
      is_br        <= '0;
      pred         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      rob_in_en    <= 1'b0;
      rob_idx_out  <= '0;
      rob_dest_out <= '0;
      rob_val_out  <= '0;
      roll_back    <= 1'b0;
      redirect_pc  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        dest[i]   <= '0;
        value[i]  <= '0;
        alt_pc[i] <= '0;
      end
    end else if (roll_back) begin
      busy      <= '0;
      ready     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      rob_in_en <= 1'b0;
      roll_back <= 1'b0;
    end else begin
      rob_in_en <= do_ret && !is_br[head];
      roll_back <= do_ret && mispred;
      count     <= count_nxt;
      full      <= count_nxt == (IDX_W+1)'(ROB_SIZE);
      if (do_ret && mispred)
        redirect_pc <= alt_pc[head];
      if (do_ret && !is_br[head]) begin
        rob_idx_out  <= head;
        rob_dest_out <= dest[head];
        rob_val_out  <= value[head];
      end
      if (do_alloc) begin
        busy[tail]   <= 1'b1;
        ready[tail]  <= 1'b0;
        dest[tail]   <= de_dest_in;
        is_br[tail]  <= de_is_br_in;
        pred[tail]   <= de_pred_in;
        alt_pc[tail] <= de_alt_pc_in;
        tail         <= tail + IDX_W'(1);
      end
      if (do_wb) begin
        ready[cdb_idx] <= 1'b1;
        value[cdb_idx] <= cdb_val;
      end
      // retire last so it wins the busy/ready update on the head entry
      if (do_ret) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed table vectors plus fill/wrap, stall and async reset sequences.
module tb_reorder_buffer;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
  logic        de_in_en, de_is_br_in, de_pred_in, cdb_en;
  logic [4:0]  de_dest_in;
  logic [31:0] de_alt_pc_in, cdb_val;
  logic [3:0]  cdb_idx, q1_idx, q2_idx;
  logic        full, q1_rdy, q2_rdy, rob_in_en, roll_back;
  logic [3:0]  alloc_idx, rob_idx_out;
  logic [31:0] q1_val, q2_val, rob_val_out, redirect_pc;
  logic [4:0]  rob_dest_out;
  int nvec = 0, nerr = 0;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .de_in_en(de_in_en), .de_dest_in(de_dest_in), .de_is_br_in(de_is_br_in),
    .de_pred_in(de_pred_in), .de_alt_pc_in(de_alt_pc_in),
    .full(full), .alloc_idx(alloc_idx),
    .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
    .q1_val(q1_val), .q2_val(q2_val),
    .rob_in_en(rob_in_en), .rob_idx_out(rob_idx_out), .rob_dest_out(rob_dest_out),
    .rob_val_out(rob_val_out), .roll_back(roll_back), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic de; logic [4:0] dest; logic br, pred; logic [31:0] alt;
    logic ce; logic [3:0] ci; logic [31:0] cv;
    logic [3:0] qi; logic qr; logic [31:0] qv;
    logic en; logic [3:0] ri; logic [4:0] rd; logic [31:0] rv;
    logic [3:0] ai; logic fl, rb; logic [31:0] rp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    de_in_en = 0; de_dest_in = 0; de_is_br_in = 0; de_pred_in = 0; de_alt_pc_in = 0;
    cdb_en = 0; cdb_idx = 0; cdb_val = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " rob_in_en"}, 32'(rob_in_en), 0);
    chk({tag, " roll_back"}, 32'(roll_back), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " alloc_idx"}, 32'(alloc_idx), 0);
    chk({tag, " rob_idx/dest"}, {rob_idx_out, rob_dest_out}, 0);
    chk({tag, " rob_val"}, rob_val_out, 0);
    chk({tag, " redirect_pc"}, redirect_pc, 0);
    chk({tag, " q1/q2_rdy"}, {q1_rdy, q2_rdy}, 0);
  endtask

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{1,5,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       1,0,0,0};
    tbl[1]  = '{0,0,0,0,0,        1,0,'h1234,  0,0,0,       0,0,0,0,       1,0,0,0};
    tbl[2]  = '{0,0,0,0,0,        0,0,0,       0,1,'h1234,  1,0,5,'h1234,  1,0,0,0};
    tbl[3]  = '{1,1,0,0,0,        0,0,0,       1,0,0,       0,0,0,0,       2,0,0,0};
    tbl[4]  = '{1,2,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       3,0,0,0};
    tbl[5]  = '{1,3,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       4,0,0,0};
    tbl[6]  = '{0,0,0,0,0,        1,3,'h33,    3,0,0,       0,0,0,0,       4,0,0,0};
    tbl[7]  = '{0,0,0,0,0,        1,2,'h22,    3,1,'h33,    0,0,0,0,       4,0,0,0};
    tbl[8]  = '{0,0,0,0,0,        1,1,'h11,    2,1,'h22,    0,0,0,0,       4,0,0,0};
    tbl[9]  = '{0,0,0,0,0,        0,0,0,       1,1,'h11,    1,1,1,'h11,    4,0,0,0};
    tbl[10] = '{0,0,0,0,0,        0,0,0,       0,0,0,       1,2,2,'h22,    4,0,0,0};
    tbl[11] = '{0,0,0,0,0,        0,0,0,       0,0,0,       1,3,3,'h33,    4,0,0,0};
    tbl[12] = '{0,0,0,0,0,        0,0,0,       3,0,0,       0,0,0,0,       4,0,0,0};
    tbl[13] = '{1,0,1,1,'h100,    0,0,0,       0,0,0,       0,0,0,0,       5,0,0,0};
    tbl[14] = '{1,7,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       6,0,0,0};
    tbl[15] = '{0,0,0,0,0,        1,5,'h55,    0,0,0,       0,0,0,0,       6,0,0,0};
    tbl[16] = '{0,0,0,0,0,        1,4,0,       0,0,0,       0,0,0,0,       6,0,0,0};
    tbl[17] = '{0,0,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       6,0,1,'h100};
    tbl[18] = '{1,9,0,0,0,        1,5,'h77,    0,0,0,       0,0,0,0,       0,0,0,0};
    tbl[19] = '{0,0,0,0,0,        0,0,0,       5,0,0,       0,0,0,0,       0,0,0,0};
    tbl[20] = '{1,0,1,1,'h200,    0,0,0,       0,0,0,       0,0,0,0,       1,0,0,0};
    tbl[21] = '{0,0,0,0,0,        1,0,1,       0,0,0,       0,0,0,0,       1,0,0,0};
    tbl[22] = '{0,0,0,0,0,        0,0,0,       0,1,1,       0,0,0,0,       1,0,0,0};
    tbl[23] = '{1,4,0,0,0,        0,0,0,       0,0,0,       0,0,0,0,       2,0,0,0};
    tbl[24] = '{0,0,0,0,0,        1,1,'h44,    0,0,0,       0,0,0,0,       2,0,0,0};
    tbl[25] = '{0,0,0,0,0,        0,0,0,       0,0,0,       1,1,4,'h44,    2,0,0,0};

    idle();
    q1_idx = 0; q2_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_in = 1'b1;

    for (int k = 0; k < 26; k++) begin
      vec_t v;
      logic hit, erdy;
      logic [31:0] eval;
      v = tbl[k];
      de_in_en = v.de; de_dest_in = v.dest; de_is_br_in = v.br; de_pred_in = v.pred;
      de_alt_pc_in = v.alt; cdb_en = v.ce; cdb_idx = v.ci; cdb_val = v.cv; q1_idx = v.qi;
      #3;
      hit  = BYP && v.ce && (v.ci == v.qi);
      erdy = v.qr || hit;
      eval = hit ? v.cv : v.qv;
      chk($sformatf("v%0d q1_rdy", k), 32'(q1_rdy), 32'(erdy));
      if (erdy) chk($sformatf("v%0d q1_val", k), q1_val, eval);
      cyc();
      chk($sformatf("v%0d rob_in_en", k), 32'(rob_in_en), 32'(v.en));
      if (v.en) begin
        chk($sformatf("v%0d rob_idx", k), 32'(rob_idx_out), 32'(v.ri));
        chk($sformatf("v%0d rob_dest", k), 32'(rob_dest_out), 32'(v.rd));
        chk($sformatf("v%0d rob_val", k), rob_val_out, v.rv);
      end
      chk($sformatf("v%0d alloc_idx", k), 32'(alloc_idx), 32'(v.ai));
      chk($sformatf("v%0d full", k), 32'(full), 32'(v.fl));
      chk($sformatf("v%0d roll_back", k), 32'(roll_back), 32'(v.rb));
      if (v.rb) chk($sformatf("v%0d redirect_pc", k), redirect_pc, v.rp);
    end

    idle();
    q1_idx = 0;
    rst_in = 1'b0;
    #1;
    check_all_zero("rst2");
    cyc();
    rst_in = 1'b1;

    for (int i = 0; i < 16; i++) begin
      de_in_en = 1; de_dest_in = 5'(i + 1);
      cyc();
      chk($sformatf("fill%0d alloc_idx", i), 32'(alloc_idx), (i + 1) % 16);
      chk($sformatf("fill%0d full", i), 32'(full), 32'(i == 15));
    end
    de_dest_in = 31;
    cyc();
    chk("drop17 full", 32'(full), 1);
    chk("drop17 alloc_idx", 32'(alloc_idx), 0);
    idle();
    cdb_en = 1; cdb_idx = 0; cdb_val = 'hA0;
    cyc();
    chk("full wb rob_in_en", 32'(rob_in_en), 0);
    idle();
    cyc();
    chk("full commit en", 32'(rob_in_en), 1);
    chk("full commit idx/dest", {rob_idx_out, rob_dest_out}, {4'd0, 5'd1});
    chk("full commit val", rob_val_out, 'hA0);
    chk("full commit full", 32'(full), 0);
    cdb_en = 1; cdb_idx = 1; cdb_val = 'hA1;
    cyc();
    idle();
    de_in_en = 1; de_dest_in = 20;
    cyc();
    chk("ret+alloc en", 32'(rob_in_en), 1);
    chk("ret+alloc dest", 32'(rob_dest_out), 2);
    chk("ret+alloc alloc_idx", 32'(alloc_idx), 1);
    chk("ret+alloc full", 32'(full), 0);
    de_dest_in = 21;
    cyc();
    chk("refill alloc_idx", 32'(alloc_idx), 2);
    chk("refill full", 32'(full), 1);

    idle();
    cdb_en = 1; cdb_idx = 2; cdb_val = 'hA2;
    cyc();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cdb_en = 1; cdb_idx = 3; cdb_val = 'hBAD;
      cyc();
      chk($sformatf("stall%0d rob_in_en", i), 32'(rob_in_en), 0);
      chk($sformatf("stall%0d full", i), 32'(full), 1);
    end
    idle();
    rdy_in = 1'b1;
    q1_idx = 3;
    #3;
    chk("stall no wb q1_rdy", 32'(q1_rdy), 0);
    cyc();
    chk("unstall en", 32'(rob_in_en), 1);
    chk("unstall idx/dest", {rob_idx_out, rob_dest_out}, {4'd2, 5'd3});
    chk("unstall val", rob_val_out, 'hA2);
    #2;
    rst_in = 1'b0;
    #1;
    check_all_zero("midrst");
    cyc();
    rst_in = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
